// File: rtl/dm_access_pkg.sv
// Shared types and defaults for the data-memory access controller.
package dm_access_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        DONE  = 2'b11
    } dm_state_e;

    localparam int unsigned DM_TIMEOUT = 64;
    localparam int unsigned DM_CNT_W   = 7;

endpackage

// File: rtl/dm_timeout_cnt.sv
// Response-wait counter; hit_o flags the last permitted WAIT cycle.
module dm_timeout_cnt
    import dm_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = DM_TIMEOUT,
    parameter int unsigned CNT_W   = DM_CNT_W
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign hit_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dm_access_ctrl.sv
// EX/DM memory-stage access controller; Done_DM holds or advances the latch.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = DM_TIMEOUT,
    parameter int unsigned CNT_W   = DM_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        EXDM_MemRead,
    input  logic        EXDM_MemWrt,
    input  logic [15:0] EXDM_ALU,
    input  logic [15:0] EXDM_RTData,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_stall,
    input  logic        mem_done,
    input  logic [15:0] mem_rdata,
    output logic        Done_DM,
    output logic [15:0] DM_rdata,
    output logic        DM_err
);

    dm_state_e   state_q;
    logic        en_q;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic        req;
    logic        bad;
    logic        hit;

    assign req = EXDM_MemRead | EXDM_MemWrt;
    assign bad = (EXDM_MemRead & EXDM_MemWrt) | EXDM_ALU[0];

    dm_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (state_q == ISSUE),
        .en_i   (state_q == WAIT),
        .hit_o  (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req && bad) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (req) begin
                        addr_q  <= EXDM_ALU;
                        wdata_q <= EXDM_RTData;
                        wr_q    <= EXDM_MemWrt;
                        en_q    <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!mem_stall) begin
                        en_q    <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        if (!wr_q) rdata_q <= mem_rdata;
                        state_q <= DONE;
                    end else if (hit) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en    = en_q;
    assign mem_wr    = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign DM_rdata  = rdata_q;
    assign Done_DM   = ((state_q == IDLE) & ~req) | (state_q == DONE);
    assign DM_err    = (state_q == DONE) & err_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with hand-computed expectations.
module tb_dm_access_ctrl;

    logic        clk;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] alu;
    logic [15:0] rt;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_stall;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        done_dm;
    logic [15:0] dm_rdata;
    logic        dm_err;

    int vectors;
    int miscompares;

    dm_access_ctrl #(
        .TIMEOUT (64),
        .CNT_W   (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .EXDM_MemRead (rd),
        .EXDM_MemWrt  (wr),
        .EXDM_ALU     (alu),
        .EXDM_RTData  (rt),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_stall    (mem_stall),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata),
        .Done_DM      (done_dm),
        .DM_rdata     (dm_rdata),
        .DM_err       (dm_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Good load: IDLE, ISSUE, WAIT with mem_done, DONE.
    task automatic do_load(input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] prev);
        @(negedge clk);
        rd = 1'b1; alu = a;
        #1;
        chk("ld_c0_done", 32'(done_dm), 32'd0);
        chk("ld_c0_en", 32'(mem_en), 32'd0);
        @(negedge clk); #1;
        chk("ld_c1_en", 32'(mem_en), 32'd1);
        chk("ld_c1_wr", 32'(mem_wr), 32'd0);
        chk("ld_c1_addr", 32'(mem_addr), 32'(a));
        chk("ld_c1_done", 32'(done_dm), 32'd0);
        @(negedge clk);
        mem_done = 1'b1; mem_rdata = d;
        #1;
        chk("ld_c2_en", 32'(mem_en), 32'd0);
        chk("ld_c2_done", 32'(done_dm), 32'd0);
        chk("ld_c2_rdata", 32'(dm_rdata), 32'(prev));
        @(negedge clk);
        mem_done = 1'b0; mem_rdata = '0; rd = 1'b0;
        #1;
        chk("ld_c3_done", 32'(done_dm), 32'd1);
        chk("ld_c3_err", 32'(dm_err), 32'd0);
        chk("ld_c3_rdata", 32'(dm_rdata), 32'(d));
        @(negedge clk); #1;
        chk("ld_c4_done", 32'(done_dm), 32'd1);
        chk("ld_c4_err", 32'(dm_err), 32'd0);
        chk("ld_c4_rdata", 32'(dm_rdata), 32'(d));
    endtask

    task automatic bad_req(input logic r, input logic w,
                           input logic [15:0] a);
        @(negedge clk);
        rd = r; wr = w; alu = a;
        #1;
        chk("bad_c0_done", 32'(done_dm), 32'd0);
        chk("bad_c0_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
        #1;
        chk("bad_c1_done", 32'(done_dm), 32'd1);
        chk("bad_c1_err", 32'(dm_err), 32'd1);
        chk("bad_c1_en", 32'(mem_en), 32'd0);
        @(negedge clk); #1;
        chk("bad_c2_done", 32'(done_dm), 32'd1);
        chk("bad_c2_err", 32'(dm_err), 32'd0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        rd = 1'b0; wr = 1'b0; alu = '0; rt = '0;
        mem_stall = 1'b0; mem_done = 1'b0; mem_rdata = '0;

        #12;
        chk("rst_en", 32'(mem_en), 32'd0);
        chk("rst_wr", 32'(mem_wr), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(dm_rdata), 32'd0);
        chk("rst_err", 32'(dm_err), 32'd0);
        chk("rst_done_noreq", 32'(done_dm), 32'd1);
        rd = 1'b1;
        #1;
        chk("rst_done_req", 32'(done_dm), 32'd0);
        rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        repeat (5) begin
            @(negedge clk); #1;
            chk("nop_done", 32'(done_dm), 32'd1);
            chk("nop_en", 32'(mem_en), 32'd0);
            chk("nop_err", 32'(dm_err), 32'd0);
        end

        do_load(16'h0010, 16'hBEEF, 16'h0000);

        // Store with three stall cycles; inputs scrambled mid-access.
        @(negedge clk);
        wr = 1'b1; alu = 16'h0020; rt = 16'h1234; mem_stall = 1'b1;
        #1;
        chk("st_c0_done", 32'(done_dm), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu = 16'hFFF0; rt = 16'h0000;
            if (i == 3) mem_stall = 1'b0;
            #1;
            chk("st_iss_en", 32'(mem_en), 32'd1);
            chk("st_iss_wr", 32'(mem_wr), 32'd1);
            chk("st_iss_addr", 32'(mem_addr), 32'h0020);
            chk("st_iss_wdata", 32'(mem_wdata), 32'h1234);
            chk("st_iss_done", 32'(done_dm), 32'd0);
        end
        @(negedge clk);
        mem_done = 1'b1; mem_rdata = 16'h7777;
        #1;
        chk("st_wait_en", 32'(mem_en), 32'd0);
        chk("st_wait_done", 32'(done_dm), 32'd0);
        @(negedge clk);
        mem_done = 1'b0; mem_rdata = '0; wr = 1'b0;
        #1;
        chk("st_done_done", 32'(done_dm), 32'd1);
        chk("st_done_err", 32'(dm_err), 32'd0);
        chk("st_done_rdata", 32'(dm_rdata), 32'hBEEF);

        bad_req(1'b1, 1'b0, 16'h0011);
        bad_req(1'b1, 1'b1, 16'h0030);

        // Read with no response: 64 WAIT cycles, then error.
        @(negedge clk);
        rd = 1'b1; alu = 16'h0040;
        #1;
        chk("to_c0_done", 32'(done_dm), 32'd0);
        @(negedge clk); #1;
        chk("to_iss_en", 32'(mem_en), 32'd1);
        repeat (64) begin
            @(negedge clk); #1;
            chk("to_wait_done", 32'(done_dm), 32'd0);
            chk("to_wait_en", 32'(mem_en), 32'd0);
        end
        @(negedge clk);
        rd = 1'b0;
        #1;
        chk("to_done_done", 32'(done_dm), 32'd1);
        chk("to_done_err", 32'(dm_err), 32'd1);
        chk("to_done_rdata", 32'(dm_rdata), 32'hBEEF);
        @(negedge clk);
        mem_done = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        chk("to_late_done", 32'(done_dm), 32'd1);
        chk("to_late_err", 32'(dm_err), 32'd0);
        @(negedge clk);
        mem_done = 1'b0; mem_rdata = '0;
        #1;
        chk("to_late_rdata", 32'(dm_rdata), 32'hBEEF);
        chk("to_late_en", 32'(mem_en), 32'd0);
        chk("to_late_done2", 32'(done_dm), 32'd1);

        // Reset asserted in WAIT.
        @(negedge clk);
        rd = 1'b1; alu = 16'h0050;
        @(negedge clk); #1;
        chk("mr_iss_en", 32'(mem_en), 32'd1);
        @(negedge clk); #1;
        chk("mr_wait_en", 32'(mem_en), 32'd0);
        rst = 1'b0;
        #1;
        chk("mr_rst_en", 32'(mem_en), 32'd0);
        chk("mr_rst_done", 32'(done_dm), 32'd0);
        chk("mr_rst_rdata", 32'(dm_rdata), 32'd0);
        mem_done = 1'b1; mem_rdata = 16'h1111;
        @(negedge clk);
        rd = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        #1;
        chk("mr_rst_idle", 32'(done_dm), 32'd1);
        chk("mr_rst_err", 32'(dm_err), 32'd0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mr_post_done", 32'(done_dm), 32'd1);
        chk("mr_post_rdata", 32'(dm_rdata), 32'd0);

        do_load(16'h0060, 16'h5A5A, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Memory-stage access controller on the consuming side of the EX/DM pipeline latch. It takes the latched memory request (MemRead/MemWrt, ALU address, RT store data) and runs it against a multi-cycle, stallable data memory. It returns load data and produces Done_DM, which is the latch's hold/advance enable: low freezes EX/DM, high lets it advance. Non-memory instructions pass with Done_DM high and no memory traffic.

Parameters:
TIMEOUT, 64, maximum WAIT-state cycles before the access is abandoned with an error
CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  reset; asynchronous, active-low
EXDM_MemRead  in  1  latched load request
EXDM_MemWrt  in  1  latched store request
EXDM_ALU  in  16  effective address
EXDM_RTData  in  16  store data
mem_en  out  1  memory request strobe (registered)
mem_wr  out  1  1 = write, 0 = read; valid while mem_en high
mem_addr  out  16  memory address; valid while mem_en high
mem_wdata  out  16  memory write data
mem_stall  in  1  memory cannot accept the request this cycle
mem_done  in  1  one-cycle pulse: read data valid or write committed
mem_rdata  in  16  read data, sampled when mem_done is high
Done_DM  out  1  access complete or no access required; EX/DM latch enable
DM_rdata  out  16  load result, held until the next load completes
DM_err  out  1  error flag for the instruction completing this cycle

Behaviour:
- req = EXDM_MemRead | EXDM_MemWrt. The request is bad if both signals are high or if EXDM_ALU[0] is 1 (misaligned word).
- States: IDLE, ISSUE, WAIT, DONE. Reset value is IDLE.
- IDLE:
  - no req: Done_DM = 1 (combinational), stay in IDLE.
  - bad req: go to DONE with err_r = 1 and no memory traffic.
  - good req: register address, wdata and wr (= EXDM_MemWrt), go to ISSUE. Done_DM = 0.
- ISSUE: mem_en = 1. If mem_stall = 1, stay in ISSUE with address, data and wr held stable. Otherwise go to WAIT and clear the counter.
- WAIT:
  - mem_en = 0 and the counter increments each cycle.
  - mem_done = 1: go to DONE. On a read, capture mem_rdata into DM_rdata.
  - counter == TIMEOUT-1 with no mem_done: go to DONE with err_r = 1. DM_rdata is unchanged.
- DONE: Done_DM = 1 for exactly one cycle, DM_err = err_r, then go to IDLE and clear err_r. The latch advances on this edge.
- Done_DM is low in ISSUE and WAIT, and low in IDLE whenever req is present.
- Minimum latency for a good access, counting from the first IDLE cycle with req: Done_DM is high in cycle 3 (IDLE, ISSUE, WAIT with mem_done, DONE).
- mem_done outside WAIT is ignored. Late responses after a timeout are discarded.
- Address and data inputs are sampled only in IDLE. Input changes during ISSUE or WAIT have no effect.
- Reset values: state IDLE, mem_en 0, mem_wr 0, mem_addr 0, mem_wdata 0, DM_rdata 0, DM_err 0, counter 0. Done_DM = ~req while in reset.
- Reset asserted mid-access returns to IDLE immediately and drops mem_en asynchronously. The in-flight memory response is ignored.
- DM_err is 0 outside DONE.

Decomposition:
- Package dm_access_pkg holds:
  - the state encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, DONE=2'b11;
  - the default TIMEOUT constant.
- One sub-module: dm_timeout_cnt, a CNT_W-bit counter with clear, enable and a hit = (count == TIMEOUT-1) output.

Test Plan:
- No request (MemRead=0, MemWrt=0) held 5 cycles -> Done_DM = 1 every cycle, mem_en never asserted, DM_err = 0.
- Load addr 0x0010, mem_stall=0, mem_done one cycle after ISSUE with mem_rdata=0xBEEF -> mem_en=1 and mem_wr=0 in cycle 1; Done_DM = 1 only in cycle 3; DM_rdata = 0xBEEF afterwards.
- Store addr 0x0020 data 0x1234, mem_stall=1 for 3 cycles -> mem_en, mem_addr=0x0020 and mem_wdata=0x1234 held for 4 ISSUE cycles; Done_DM = 0 until DONE; DM_rdata unchanged.
- Bad requests: load at 0x0011, and MemRead=MemWrt=1 -> no mem_en; DONE reached in the next cycle with DM_err = 1 for one cycle.
- Read with no mem_done, TIMEOUT=64 -> DONE after 64 WAIT cycles with DM_err = 1; a mem_done arriving in the following IDLE is ignored.
- rst driven low during WAIT -> mem_en=0 and state IDLE immediately; after release, a new load completes normally.
